// File: rtl/fp16_align_unit_pkg.sv
// Shared widths, FSM encoding and FP16 field layout for the FP16 adder alignment stage.
package fp16_align_unit_pkg;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 4;
  localparam int CNT_W  = $clog2(MANT_W);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] D_LIMIT = EXP_W'(MANT_W);

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;
endpackage

// File: rtl/fp16_align_unit_if.sv
// Operand request / aligned-result handshake bundle for the alignment stage.
interface fp16_align_unit_if;
  import fp16_align_unit_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP_W-1:0]   op_a;
  logic [FP_W-1:0]   op_b;
  logic              sub_op;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_big;
  logic [MANT_W-1:0] mant_small;
  logic              sign_big;
  logic              eff_sub;
  logic              is_nan;
  logic              is_inf;

  modport master (
    output in_valid, op_a, op_b, sub_op, out_ready,
    input  in_ready, out_valid, exp_out, mant_big, mant_small,
           sign_big, eff_sub, is_nan, is_inf
  );

  modport slave (
    input  in_valid, op_a, op_b, sub_op, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small,
           sign_big, eff_sub, is_nan, is_inf
  );
endinterface

// File: rtl/fp16_align_unit_unpack.sv
// Combinational FP16 field decode: effective exponent, hidden-bit mantissa, class flags.
module fp16_unpack
  import fp16_align_unit_pkg::*;
(
  input  fp16_t             i_op,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_eexp,
  output logic [FRAC_W:0]   o_mant,
  output logic              o_is_nan,
  output logic              o_is_inf
);
  logic w_exp_zero;
  logic w_exp_max;

  assign w_exp_zero = (i_op.exp == '0);
  assign w_exp_max  = (i_op.exp == EXP_MAX);

  // Subnormals share the exponent of the smallest normal, without the hidden bit.
  assign o_sign   = i_op.sign;
  assign o_eexp   = w_exp_zero ? EXP_W'(1) : i_op.exp;
  assign o_mant   = {~w_exp_zero, i_op.frac};
  assign o_is_nan = w_exp_max && (i_op.frac != '0);
  assign o_is_inf = w_exp_max && (i_op.frac == '0);
endmodule

// File: rtl/fp16_align_unit.sv
// FP16 adder alignment stage: orders operands by magnitude and serially right-shifts
// the smaller mantissa (one bit per cycle, sticky in bit 0) to the common exponent.
module fp16_align_unit
  import fp16_align_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fp16_align_unit_if.slave   if_bus
);
  state_e            r_state, w_state_nxt;
  fp16_t             r_op_a, r_op_b;
  logic              r_sub;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [EXP_W-1:0]  r_exp, w_exp_nxt;
  logic [MANT_W-1:0] r_mant_big, w_mant_big_nxt;
  logic [MANT_W-1:0] r_mant_small, w_mant_small_nxt;
  logic              r_sign_big, w_sign_big_nxt;
  logic              r_eff_sub, w_eff_sub_nxt;
  logic              r_nan, w_nan_nxt;
  logic              r_inf, w_inf_nxt;

  logic              w_sa, w_sb, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic [EXP_W-1:0]  w_ea, w_eb, w_e_big, w_e_small, w_d;
  logic [FRAC_W:0]   w_ma, w_mb;
  logic [MANT_W-1:0] w_m_big, w_m_small;
  logic              w_a_big, w_sb_eff, w_eff_sub, w_sign_big, w_special, w_nan_res;

  fp16_unpack u_unpack_a (
    .i_op     (r_op_a),
    .o_sign   (w_sa),
    .o_eexp   (w_ea),
    .o_mant   (w_ma),
    .o_is_nan (w_nan_a),
    .o_is_inf (w_inf_a)
  );

  fp16_unpack u_unpack_b (
    .i_op     (r_op_b),
    .o_sign   (w_sb),
    .o_eexp   (w_eb),
    .o_mant   (w_mb),
    .o_is_nan (w_nan_b),
    .o_is_inf (w_inf_b)
  );

  // Equal effective exponents compare the full mantissa so a normal with exp=1
  // still beats a subnormal; a complete tie keeps A as the big operand.
  assign w_a_big    = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
  assign w_e_big    = w_a_big ? w_ea : w_eb;
  assign w_e_small  = w_a_big ? w_eb : w_ea;
  assign w_d        = w_e_big - w_e_small;
  assign w_m_big    = {(w_a_big ? w_ma : w_mb), 3'b000};
  assign w_m_small  = {(w_a_big ? w_mb : w_ma), 3'b000};
  assign w_sb_eff   = w_sb ^ r_sub;
  assign w_eff_sub  = w_sa ^ w_sb ^ r_sub;
  assign w_sign_big = w_a_big ? w_sa : w_sb_eff;
  assign w_special  = (r_op_a.exp == EXP_MAX) || (r_op_b.exp == EXP_MAX);
  assign w_nan_res  = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_eff_sub);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_exp_nxt        = r_exp;
    w_mant_big_nxt   = r_mant_big;
    w_mant_small_nxt = r_mant_small;
    w_sign_big_nxt   = r_sign_big;
    w_eff_sub_nxt    = r_eff_sub;
    w_nan_nxt        = r_nan;
    w_inf_nxt        = r_inf;
    case (r_state)
      IDLE: begin
        if (if_bus.in_valid) w_state_nxt = COMPARE;
      end
      COMPARE: begin
        w_exp_nxt        = w_e_big;
        w_mant_big_nxt   = w_m_big;
        w_mant_small_nxt = w_m_small;
        w_sign_big_nxt   = w_sign_big;
        w_eff_sub_nxt    = w_eff_sub;
        w_nan_nxt        = 1'b0;
        w_inf_nxt        = 1'b0;
        w_cnt_nxt        = w_d[CNT_W-1:0];
        if (w_special) begin
          w_nan_nxt   = w_nan_res;
          w_inf_nxt   = !w_nan_res;
          if (!w_nan_res) w_sign_big_nxt = w_inf_a ? w_sa : w_sb_eff;
          w_state_nxt = DONE;
        end else if (w_d == '0) begin
          w_state_nxt = DONE;
        end else if (w_d >= D_LIMIT) begin
          // Everything shifts out: only the sticky survives.
          w_mant_small_nxt = {{(MANT_W-1){1'b0}}, |w_m_small};
          w_state_nxt      = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_mant_small_nxt = {1'b0, r_mant_small[MANT_W-1:2], r_mant_small[1] | r_mant_small[0]};
        w_cnt_nxt        = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        if (if_bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_sub        <= 1'b0;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_sign_big   <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_nan        <= 1'b0;
      r_inf        <= 1'b0;
    end else begin
      if (r_state == IDLE && if_bus.in_valid) begin
        r_op_a <= fp16_t'(if_bus.op_a);
        r_op_b <= fp16_t'(if_bus.op_b);
        r_sub  <= if_bus.sub_op;
      end
      r_cnt        <= w_cnt_nxt;
      r_exp        <= w_exp_nxt;
      r_mant_big   <= w_mant_big_nxt;
      r_mant_small <= w_mant_small_nxt;
      r_sign_big   <= w_sign_big_nxt;
      r_eff_sub    <= w_eff_sub_nxt;
      r_nan        <= w_nan_nxt;
      r_inf        <= w_inf_nxt;
    end
  end

  assign if_bus.in_ready   = (r_state == IDLE) && !reset;
  assign if_bus.out_valid  = (r_state == DONE);
  assign if_bus.exp_out    = r_exp;
  assign if_bus.mant_big   = r_mant_big;
  assign if_bus.mant_small = r_mant_small;
  assign if_bus.sign_big   = r_sign_big;
  assign if_bus.eff_sub    = r_eff_sub;
  assign if_bus.is_nan     = r_nan;
  assign if_bus.is_inf     = r_inf;
endmodule
